// File: rtl/dmem_mmio_bridge.sv
// dmem_mmio_bridge
//   Sits between the processor data port and dmem. Ordinary loads and stores
//   pass straight through. A 16-word window at MMIO_BASE is handled locally and
//   holds three registers:
//     offset 0x0 TX_DATA : write pushes a byte into the transmit FIFO; read
//                          peeks at the head byte (0 when empty)
//     offset 0x1 STATUS  : {count[8:3], overflow[2], full[1], empty[0]};
//                          writing 1 to bit 2 clears the sticky overflow flag
//     offset 0x2 CYCLE   : free-running 32-bit counter; a write loads it
//   The FIFO drains through a valid/ready byte stream.
//
// Ports
//   clock, reset               processor clock, async active-low reset
//   proc_address/data/wren     processor data-port request
//   proc_q                     read data back to the processor
//   dmem_address/data/wren     request forwarded to dmem
//   dmem_q                     read data from dmem
//   tx_data, tx_valid          FIFO head byte stream
//   tx_ready                   consumer accepts the head byte
//
// Stream handshake: a byte moves on every rising edge where tx_valid and
// tx_ready are both 1. tx_valid/tx_data come only from registered state, and
// the head byte stays put while tx_valid=1 and tx_ready=0.
module dmem_mmio_bridge #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [11:0] MMIO_BASE  = 12'hFF0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] proc_address,
    input  logic [31:0] proc_data,
    input  logic        proc_wren,
    output logic [31:0] proc_q,
    output logic [11:0] dmem_address,
    output logic [31:0] dmem_data,
    output logic        dmem_wren,
    input  logic [31:0] dmem_q,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [31:0]   cycle;

    logic          hit;
    logic [3:0]    offset;
    logic          empty;
    logic          full;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          ovf_event;
    logic          ovf_clear;
    logic          cycle_wr;
    logic [5:0]    count_field;
    logic [31:0]   status;
    logic [31:0]   mmio_rdata;

    assign hit    = (proc_address[11:4] == MMIO_BASE[11:4]);
    assign offset = proc_address[3:0];

    assign dmem_address = proc_address;
    assign dmem_data    = proc_data;
    assign dmem_wren    = proc_wren & ~hit;

    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);
    assign tx_valid = ~empty;
    // Storage is not reset, so mask the head byte when nothing is queued.
    assign tx_data  = tx_valid ? mem[rd_ptr] : 8'h00;

    assign pop       = tx_valid & tx_ready;
    assign push_req  = proc_wren & hit & (offset == 4'h0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok   = push_req & (~full | pop);
    assign ovf_event = push_req & full & ~pop;
    assign ovf_clear = proc_wren & hit & (offset == 4'h1) & proc_data[2];
    assign cycle_wr  = proc_wren & hit & (offset == 4'h2);

    assign count_field = 6'(count);
    assign status      = {23'b0, count_field, overflow, full, empty};

    always_comb begin
        mmio_rdata = 32'h0;
        case (offset)
            4'h0:    mmio_rdata = {24'b0, tx_data};
            4'h1:    mmio_rdata = status;
            4'h2:    mmio_rdata = cycle;
            default: mmio_rdata = 32'h0;
        endcase
    end

    assign proc_q = hit ? mmio_rdata : dmem_q;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= proc_data[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // A new overflow wins over a clear landing in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (ovf_event) begin
            overflow <= 1'b1;
        end else if (ovf_clear) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle <= 32'h0;
        end else if (cycle_wr) begin
            cycle <= proc_data;
        end else begin
            cycle <= cycle + 32'd1;
        end
    end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
module tb_dmem_mmio_bridge;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] proc_address = 12'h0;
    logic [31:0] proc_data = 32'h0;
    logic        proc_wren = 1'b0;
    logic [31:0] proc_q;
    logic [11:0] dmem_address;
    logic [31:0] dmem_data;
    logic        dmem_wren;
    logic [31:0] dmem_q = 32'h0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int          vec_cnt = 0;
    int          miscompare_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] rdata;
    logic [31:0] c1;
    logic [31:0] c2;

    localparam logic [11:0] A_TX     = 12'hFF0;
    localparam logic [11:0] A_STATUS = 12'hFF1;
    localparam logic [11:0] A_CYCLE  = 12'hFF2;
    localparam logic [11:0] A_UNUSED = 12'hFF5;

    dmem_mmio_bridge #(.FIFO_DEPTH(4), .MMIO_BASE(12'hFF0)) dut (
        .clock        (clock),
        .reset        (reset),
        .proc_address (proc_address),
        .proc_data    (proc_data),
        .proc_wren    (proc_wren),
        .proc_q       (proc_q),
        .dmem_address (dmem_address),
        .dmem_data    (dmem_data),
        .dmem_wren    (dmem_wren),
        .dmem_q       (dmem_q),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // drivers: inputs change on the falling edge, state moves on the rising edge
    task automatic bus_write(input logic [11:0] addr, input logic [31:0] data);
        @(negedge clock);
        proc_address = addr;
        proc_data    = data;
        proc_wren    = 1'b1;
        @(posedge clock);
        #1 proc_wren = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] addr, output logic [31:0] data);
        @(negedge clock);
        proc_address = addr;
        proc_wren    = 1'b0;
        #1 data = proc_q;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit track);
        bus_write(A_TX, {24'hABCDEF, b});
        if (track) exp_q.push_back(b);
    endtask

    // drains everything in the scoreboard, one byte per cycle
    task automatic drain_check(input string tag);
        logic [7:0] exp_b;
        @(negedge clock);
        tx_ready = 1'b1;
        while (exp_q.size() > 0) begin
            #1;
            exp_b = exp_q.pop_front();
            check_eq({tag, "_valid"}, {31'b0, tx_valid}, 32'h1);
            check_eq({tag, "_data"}, {24'b0, tx_data}, {24'b0, exp_b});
            @(negedge clock);
        end
        tx_ready = 1'b0;
        #1 check_eq({tag, "_empty"}, {31'b0, tx_valid}, 32'h0);
    endtask

    initial begin
        // reset state
        #1;
        check_eq("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check_eq("rst_tx_data", {24'b0, tx_data}, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        bus_read(A_STATUS, rdata);
        check_eq("rst_status", rdata, 32'h1);

        // passthrough
        @(negedge clock);
        proc_address = 12'h010;
        proc_data    = 32'hDEADBEEF;
        proc_wren    = 1'b1;
        #1;
        check_eq("pt_wren", {31'b0, dmem_wren}, 32'h1);
        check_eq("pt_addr", {20'b0, dmem_address}, 32'h010);
        check_eq("pt_data", dmem_data, 32'hDEADBEEF);
        @(posedge clock);
        #1 proc_wren = 1'b0;
        dmem_q = 32'h12345678;
        bus_read(12'h010, rdata);
        check_eq("pt_read", rdata, 32'h12345678);
        bus_read(A_STATUS, rdata);
        check_eq("pt_hit_read_mmio", rdata, 32'h1);

        // MMIO store is blocked from dmem and pushes a byte
        @(negedge clock);
        proc_address = A_TX;
        proc_data    = 32'h0000005A;
        proc_wren    = 1'b1;
        #1 check_eq("mmio_wren_blocked", {31'b0, dmem_wren}, 32'h0);
        check_eq("push_pre_valid", {31'b0, tx_valid}, 32'h0);
        @(posedge clock);
        #1 proc_wren = 1'b0;
        check_eq("push_lat_valid", {31'b0, tx_valid}, 32'h1);
        check_eq("push_lat_data", {24'b0, tx_data}, 32'h5A);
        bus_read(A_TX, rdata);
        check_eq("tx_peek", rdata, 32'h5A);
        exp_q.push_back(8'h5A);
        drain_check("drain0");

        // unused offset: read 0, write has no side effect
        bus_write(A_UNUSED, 32'hFFFFFFFF);
        bus_read(A_UNUSED, rdata);
        check_eq("unused_read", rdata, 32'h0);
        bus_read(A_STATUS, rdata);
        check_eq("unused_wr_status", rdata, 32'h1);

        // fill and overflow
        push_byte(8'h11, 1'b1);
        push_byte(8'h22, 1'b1);
        push_byte(8'h33, 1'b1);
        push_byte(8'h44, 1'b1);
        bus_read(A_STATUS, rdata);
        check_eq("full_status", rdata, 32'h22);
        push_byte(8'h55, 1'b0);
        bus_read(A_STATUS, rdata);
        check_eq("ovf_status", rdata, 32'h26);
        check_eq("ovf_head", {24'b0, tx_data}, 32'h11);
        bus_write(A_STATUS, 32'h4);
        bus_read(A_STATUS, rdata);
        check_eq("ovf_clear", rdata, 32'h22);

        // drain order
        drain_check("drain1");
        bus_read(A_STATUS, rdata);
        check_eq("drain1_status", rdata, 32'h1);

        // push and pop together while full
        push_byte(8'h01, 1'b1);
        push_byte(8'h02, 1'b1);
        push_byte(8'h03, 1'b1);
        push_byte(8'h04, 1'b1);
        @(negedge clock);
        proc_address = A_TX;
        proc_data    = 32'h000000AA;
        proc_wren    = 1'b1;
        tx_ready     = 1'b1;
        #1 check_eq("pp_head", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
        exp_q.push_back(8'hAA);
        @(posedge clock);
        #1 proc_wren = 1'b0;
        tx_ready = 1'b0;
        bus_read(A_STATUS, rdata);
        check_eq("pp_status", rdata, 32'h22);
        drain_check("drain2");

        // cycle counter
        bus_read(A_CYCLE, c1);
        repeat (4) @(negedge clock);
        bus_read(A_CYCLE, c2);
        check_eq("cycle_delta", c2 - c1, 32'd5);
        bus_write(A_CYCLE, 32'hFFFFFFFE);
        bus_read(A_CYCLE, rdata);
        check_eq("cycle_load", rdata, 32'hFFFFFFFE);
        bus_read(A_CYCLE, rdata);
        check_eq("cycle_max", rdata, 32'hFFFFFFFF);
        bus_read(A_CYCLE, rdata);
        check_eq("cycle_wrap", rdata, 32'h0);

        // async reset with 3 bytes queued
        push_byte(8'h07, 1'b0);
        push_byte(8'h08, 1'b0);
        push_byte(8'h09, 1'b0);
        @(negedge clock);
        proc_address = A_STATUS;
        #1;
        check_eq("ar_pre_valid", {31'b0, tx_valid}, 32'h1);
        check_eq("ar_pre_status", proc_q, 32'h18);
        #1 reset = 1'b0;
        #1;
        check_eq("ar_valid", {31'b0, tx_valid}, 32'h0);
        check_eq("ar_data", {24'b0, tx_data}, 32'h0);
        check_eq("ar_status", proc_q, 32'h1);
        @(negedge clock);
        proc_address = A_CYCLE;
        #1 check_eq("ar_cycle", proc_q, 32'h0);
        reset = 1'b1;
        bus_read(A_STATUS, rdata);
        check_eq("ar_post_status", rdata, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
